vram_access_scheduler: RTL and testbench

- Single-port scheduler for the 32-bit video/data RAM.
- Shares one memory port between two requesters:
  - the pipeline MEM stage (scalar/vector loads and stores);
  - a bulk sweep engine that streams the whole RAM to the cryptography/VGA path when a transfer is requested.
- Stalls the pipeline while the sweep owns the port. Bounds sweep bursts so the CPU is never starved.

---
 rtl/vram_access_scheduler.sv | 166 ++++++++++++++++
 tb/tb_vram_access_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_scheduler.sv
// vram_access_scheduler: arbitrates one RAM port between the MEM-stage CPU access and a
// bulk sweep that streams words 0..NUM_WORDS-1 out for the crypto/VGA path. Sweep bursts
// are capped at SWEEP_BURST reads while the CPU waits, so the pipeline is never starved.
// Optional: define VRAM_STALL_COUNT_EN to add the stall_cycles counter output.
module vram_access_scheduler #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_WORDS   = 76800,
  parameter int unsigned SWEEP_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              xfer_start,
  output logic              xfer_busy,
  output logic              xfer_done,
`ifdef VRAM_STALL_COUNT_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] stream_data,
  output logic [ADDR_W-1:0] stream_addr,
  output logic              stream_valid
);

  localparam int unsigned BurstW = $clog2(SWEEP_BURST + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_WORDS - 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(SWEEP_BURST);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] sweep_addr_q;
  logic [BurstW-1:0] burst_cnt_q;
  logic              xfer_start_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              cpu_rvalid_q;
  logic              stream_valid_q;
  logic [ADDR_W-1:0] stream_addr_q;
  logic              xfer_done_q;

  logic start_edge;
  logic cpu_grant;
  logic sweep_rd;
  logic last_rd;

  // Slot decode: who owns the RAM port this cycle, and what the port carries.
  always_comb begin
    start_edge = xfer_start & ~xfer_start_q;
    cpu_grant  = 1'b0;
    sweep_rd   = 1'b0;
    unique case (state_q)
      StIdle, StDrain: cpu_grant = cpu_req;
      StSweep: begin
        if (!xfer_start) begin
          // Abort cycle: no sweep read, port is free for the CPU.
          cpu_grant = cpu_req;
        end else if (cpu_req && (burst_cnt_q == BurstMax)) begin
          cpu_grant = 1'b1;
        end else begin
          sweep_rd = 1'b1;
        end
      end
      default: ;
    endcase
    last_rd = sweep_rd && (sweep_addr_q == LastAddr);

    mem_addr  = mem_addr_q;
    mem_wren  = 1'b0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_addr = cpu_addr;
      mem_wren = cpu_we;
      if (cpu_we) mem_wdata = cpu_wdata;
    end else if (sweep_rd) begin
      mem_addr = sweep_addr_q;
    end
  end

  assign cpu_stall    = cpu_req & ~cpu_grant;
  assign xfer_busy    = (state_q == StSweep) || (state_q == StDrain);
  assign xfer_done    = xfer_done_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign stream_valid = stream_valid_q;
  assign stream_addr  = stream_addr_q;
  // mem_q is only meaningful the cycle after a read; keep the outputs clean otherwise.
  assign cpu_rdata    = cpu_rvalid_q ? mem_q : '0;
  assign stream_data  = stream_valid_q ? mem_q : '0;

  // Scheduler FSM plus the registered return-path strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      sweep_addr_q   <= '0;
      burst_cnt_q    <= '0;
      xfer_start_q   <= 1'b0;
      mem_addr_q     <= '0;
      cpu_rvalid_q   <= 1'b0;
      stream_valid_q <= 1'b0;
      stream_addr_q  <= '0;
      xfer_done_q    <= 1'b0;
    end else begin
      xfer_start_q   <= xfer_start;
      mem_addr_q     <= mem_addr;
      cpu_rvalid_q   <= cpu_grant & ~cpu_we;
      stream_valid_q <= sweep_rd;
      xfer_done_q    <= 1'b0;
      if (sweep_rd) stream_addr_q <= sweep_addr_q;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q      <= StSweep;
            sweep_addr_q <= '0;
            burst_cnt_q  <= '0;
          end
        end
        StSweep: begin
          if (!xfer_start) begin
            state_q <= StIdle;
          end else if (cpu_grant) begin
            burst_cnt_q <= '0;
          end else begin
            if (burst_cnt_q != BurstMax) burst_cnt_q <= burst_cnt_q + BurstW'(1);
            if (last_rd) begin
              state_q <= StDrain;
            end else begin
              sweep_addr_q <= sweep_addr_q + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          state_q     <= StIdle;
          xfer_done_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef VRAM_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled cycles, restarted by each new transfer request.
  always_ff @(posedge clk) begin
    if (reset || start_edge) begin
      stall_cnt_q <= '0;
    end else if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Bench for vram_access_scheduler with NUM_WORDS=8, SWEEP_BURST=2 and a 32-word RAM model.
module tb_vram_access_scheduler;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int B  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          xfer_start, xfer_busy, xfer_done;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] stream_data;
  logic [AW-1:0] stream_addr;
  logic          stream_valid;
`ifdef VRAM_STALL_COUNT_EN
  logic [15:0]   stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ram [32];
  logic [DW-1:0] shadow [32];

  always #5 clk = ~clk;

  // Registered single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    mem_q <= ram[mem_addr[4:0]];
    if (mem_wren) ram[mem_addr[4:0]] <= mem_wdata;
  end

  vram_access_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N), .SWEEP_BURST(B)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .xfer_start(xfer_start), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
`ifdef VRAM_STALL_COUNT_EN
    .stall_cycles(stall_cycles),
`endif
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q),
    .stream_data(stream_data), .stream_addr(stream_addr), .stream_valid(stream_valid)
  );

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    xfer_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({cpu_stall, cpu_rvalid, xfer_busy, xfer_done, mem_wren, stream_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000",
               {cpu_stall, cpu_rvalid, xfer_busy, xfer_done, mem_wren, stream_valid});
    end
    total++;
    if ({mem_addr, stream_addr, cpu_rdata, stream_data, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_buses got addr=%0h saddr=%0h rdata=%0h sdata=%0h wdata=%0h exp=0",
               mem_addr, stream_addr, cpu_rdata, stream_data, mem_wdata);
    end
  endtask

  task automatic test_cpu_idle();
    logic          pend;
    logic [DW-1:0] pdata;
    // Directed store then load of address 5.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({mem_wren, cpu_stall} !== 2'b10 || mem_addr !== 5 || mem_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL idle_store got wren=%b stall=%b addr=%0h wdata=%0h exp 1 0 5 deadbeef",
               mem_wren, cpu_stall, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_wren, cpu_stall} !== 2'b00 || mem_addr !== 5) begin
      bad++;
      $display("FAIL idle_load_issue got wren=%b stall=%b addr=%0h exp 0 0 5",
               mem_wren, cpu_stall, mem_addr);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL idle_load_data got rvalid=%b rdata=%0h exp 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    total++;
    if (mem_addr !== 5 || mem_wren !== 1'b0) begin
      bad++;
      $display("FAIL idle_addr_hold got addr=%0h wren=%b exp 5 0", mem_addr, mem_wren);
    end
    // Initialise every word, then random traffic against the shadow copy.
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(i); cpu_wdata = DW'(i) ^ 32'h5A5A0000;
      shadow[i] = DW'(i) ^ 32'h5A5A0000;
    end
    pend = 1'b0; pdata = '0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      cpu_req   = (i != 24);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = AW'($urandom_range(0, 31));
      cpu_wdata = $urandom;
      @(negedge clk);
      total++;
      if (cpu_rvalid !== pend || (pend && cpu_rdata !== pdata)) begin
        bad++;
        $display("FAIL idle_rand_load got rvalid=%b rdata=%0h exp %b %0h",
                 cpu_rvalid, cpu_rdata, pend, pdata);
      end
      pend = 1'b0;
      if (cpu_req) begin
        total++;
        if (cpu_stall !== 1'b0 || mem_wren !== cpu_we || mem_addr !== cpu_addr) begin
          bad++;
          $display("FAIL idle_rand_port got stall=%b wren=%b addr=%0h exp 0 %b %0h",
                   cpu_stall, mem_wren, mem_addr, cpu_we, cpu_addr);
        end
        pend  = ~cpu_we;
        pdata = shadow[cpu_addr[4:0]];
        if (cpu_we) shadow[cpu_addr[4:0]] = cpu_wdata;
      end
    end
    // Leave word == address for the sweep tests.
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(i); cpu_wdata = DW'(i);
      shadow[i] = DW'(i);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // Uncontended sweep: edge at k=0, reads k=1..N, drain k=N+1, done k=N+2.
  task automatic test_sweep();
    @(posedge clk); #1;
    xfer_start = 1'b1;
    for (int k = 0; k < N + 7; k++) begin
      @(negedge clk);
      total++;
      if (xfer_busy !== (k >= 1 && k <= N + 1)) begin
        bad++;
        $display("FAIL sweep_busy k=%0d got=%b", k, xfer_busy);
      end
      total++;
      if (xfer_done !== (k == N + 2)) begin
        bad++;
        $display("FAIL sweep_done k=%0d got=%b exp=%b", k, xfer_done, k == N + 2);
      end
      total++;
      if (stream_valid !== (k >= 2 && k <= N + 1)) begin
        bad++;
        $display("FAIL sweep_valid k=%0d got=%b", k, stream_valid);
      end else if (stream_valid && (stream_addr !== AW'(k - 2) || stream_data !== DW'(k - 2))) begin
        bad++;
        $display("FAIL sweep_word k=%0d got addr=%0h data=%0h exp %0h", k, stream_addr,
                 stream_data, k - 2);
      end
      if (k >= 1 && k <= N) begin
        total++;
        if (mem_addr !== AW'(k - 1) || mem_wren !== 1'b0) begin
          bad++;
          $display("FAIL sweep_port k=%0d got addr=%0h wren=%b exp %0h 0", k, mem_addr,
                   mem_wren, k - 1);
        end
      end
      @(posedge clk); #1;
    end
    xfer_start = 1'b0;
  endtask

  // CPU always requesting with random ops: with the CPU never idle the sweep gets
  // B slots then the CPU one, so sweep slot s is the CPU's iff s % (B+1) == B.
  task automatic test_sweep_cpu();
    int            reads, done_k, stalls;
    logic          g, r, prev_rd, prev_ld;
    logic [DW-1:0] prev_sdata, prev_ldata;
    logic [AW-1:0] prev_saddr;
    reads = 0; done_k = -1; stalls = 0;
    prev_rd = 1'b0; prev_ld = 1'b0; prev_sdata = '0; prev_ldata = '0; prev_saddr = '0;
    @(posedge clk); #1;
    xfer_start = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = $urandom;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin
        g = 1'b1; r = 1'b0;
      end else if (reads < N) begin
        r = ((k - 1) % (B + 1)) != B;
        g = ~r;
      end else begin
        g = 1'b1; r = 1'b0;
        if (done_k < 0) done_k = k + 1;
      end
      @(negedge clk);
      total++;
      if (cpu_stall !== ~g) begin
        bad++;
        $display("FAIL mix_stall k=%0d got=%b exp=%b", k, cpu_stall, ~g);
      end
      total++;
      if (g && (mem_wren !== cpu_we || mem_addr !== cpu_addr ||
                (cpu_we && mem_wdata !== cpu_wdata))) begin
        bad++;
        $display("FAIL mix_cpu_port k=%0d got wren=%b addr=%0h exp %b %0h", k, mem_wren,
                 mem_addr, cpu_we, cpu_addr);
      end else if (r && (mem_wren !== 1'b0 || mem_addr !== AW'(reads))) begin
        bad++;
        $display("FAIL mix_sweep_port k=%0d got wren=%b addr=%0h exp 0 %0h", k, mem_wren,
                 mem_addr, reads);
      end
      total++;
      if (stream_valid !== prev_rd ||
          (prev_rd && (stream_addr !== prev_saddr || stream_data !== prev_sdata))) begin
        bad++;
        $display("FAIL mix_stream k=%0d got v=%b a=%0h d=%0h exp %b %0h %0h", k, stream_valid,
                 stream_addr, stream_data, prev_rd, prev_saddr, prev_sdata);
      end
      total++;
      if (cpu_rvalid !== prev_ld || (prev_ld && cpu_rdata !== prev_ldata)) begin
        bad++;
        $display("FAIL mix_load k=%0d got v=%b d=%0h exp %b %0h", k, cpu_rvalid, cpu_rdata,
                 prev_ld, prev_ldata);
      end
      total++;
      if (xfer_done !== (k == done_k)) begin
        bad++;
        $display("FAIL mix_done k=%0d got=%b", k, xfer_done);
      end
      prev_rd = r; prev_ld = 1'b0;
      if (!g) stalls++;
      if (g) begin
        prev_ld    = ~cpu_we;
        prev_ldata = shadow[cpu_addr[4:0]];
        if (cpu_we) shadow[cpu_addr[4:0]] = cpu_wdata;
      end
      if (r) begin
        prev_saddr = AW'(reads);
        prev_sdata = shadow[reads];
        reads++;
      end
      @(posedge clk); #1;
      if (g) begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom_range(0, 31));
        cpu_wdata = $urandom;
      end
    end
    total++;
    if (done_k != N + N / B + 1) begin
      bad++;
      $display("FAIL mix_length got=%0d exp=%0d", done_k, N + N / B + 1);
    end
`ifdef VRAM_STALL_COUNT_EN
    total++;
    if (stall_cycles !== 16'(stalls)) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=%0d", stall_cycles, stalls);
    end
`endif
    cpu_req = 1'b0; xfer_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort_reset();
    // Abort after address 3 was issued.
    @(posedge clk); #1;
    xfer_start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) xfer_start = 1'b0;
      @(negedge clk);
      total++;
      if (stream_valid !== (k >= 2 && k <= 5) || (stream_valid && stream_addr !== AW'(k - 2))) begin
        bad++;
        $display("FAIL abort_stream k=%0d got v=%b a=%0h", k, stream_valid, stream_addr);
      end
      total++;
      if (xfer_done !== 1'b0 || xfer_busy !== (k >= 1 && k <= 5)) begin
        bad++;
        $display("FAIL abort_state k=%0d got done=%b busy=%b", k, xfer_done, xfer_busy);
      end
      if (k == 5) begin
        total++;
        if (mem_addr !== 3 || mem_wren !== 1'b0) begin
          bad++;
          $display("FAIL abort_port got addr=%0h wren=%b exp 3 0", mem_addr, mem_wren);
        end
      end
      @(posedge clk); #1;
    end
    // New sweep, reset while address 5 is being read.
    xfer_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (mem_addr !== 5 || xfer_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_setup got addr=%0h busy=%b exp 5 1", mem_addr, xfer_busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; xfer_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({cpu_stall, cpu_rvalid, xfer_busy, xfer_done, mem_wren, stream_valid} !== 6'b0 ||
          {mem_addr, stream_addr, stream_data, cpu_rdata} !== '0) begin
        bad++;
        $display("FAIL reset_mid k=%0d got flags=%b addr=%0h saddr=%0h sdata=%0h", k,
                 {cpu_stall, cpu_rvalid, xfer_busy, xfer_done, mem_wren, stream_valid},
                 mem_addr, stream_addr, stream_data);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef VRAM_STALL_COUNT_EN
  task automatic test_stall_saturate();
    @(posedge clk); #1;
    xfer_start = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3;
    @(posedge clk); #1;
    dut.stall_cnt_q = 16'hFFFE;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF) begin
      bad++;
      $display("FAIL stall_saturate got=%0h exp=ffff", stall_cycles);
    end
    xfer_start = 1'b0; cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_idle();
    test_sweep();
    test_sweep_cpu();
    test_abort_reset();
`ifdef VRAM_STALL_COUNT_EN
    test_stall_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
